// File: rtl/inst_fetch.sv
// inst_fetch: program counter and fetch sequencer for a combinational
// instruction memory. Owns start, sequential advance, absolute/relative
// branches, stalls and halt detection.
// Optional feature: define INST_FETCH_CYCLE_COUNT_EN to build the saturating
// RUN-cycle counter on CycleCount; otherwise CycleCount is tied to 0.
//
// Handshake: there is no valid/ready pair here. InstAddress is presented every
// cycle; InstValid=1 means InstIn is live and will be consumed at the next
// rising edge unless Stall is high, in which case the same address and
// instruction are presented again and nothing is consumed.
module inst_fetch #(
  parameter int            PW        = 11,
  parameter int            IW        = 9,
  parameter logic [IW-1:0] HALT_WORD = 9'h1FF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          BranchAbs,
  input  logic          BranchRel,
  input  logic [PW-1:0] Target,
  input  logic [IW-1:0] InstIn,
  output logic [PW-1:0] InstAddress,
  output logic          InstValid,
  output logic          Halt,
  output logic          Done,
  output logic [15:0]   CycleCount,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          done_q, done_d;
  logic          halt_hit;

  // A halt word is only consumed in an unstalled RUN cycle that is not a restart.
  assign halt_hit = (state_q == ST_RUN) && !Start && !Stall && (InstIn == HALT_WORD);

  // State, PC and Done registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-PC selection, in priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = halt_hit;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = StartAddr;
        end
      end
      ST_RUN: begin
        if (Start) begin
          pc_d = StartAddr;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (InstIn == HALT_WORD) begin
          state_d = ST_HALTED;
          pc_d    = pc_q;
        end else if (BranchAbs) begin
          pc_d = Target;
        end else if (BranchRel) begin
          pc_d = pc_q + Target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = StartAddr;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    InstAddress = pc_q;
    InstValid   = (state_q == ST_RUN);
    Halt        = (state_q == ST_HALTED);
    Done        = done_q;
    dbg_state   = state_q;
  end

`ifdef INST_FETCH_CYCLE_COUNT_EN
  logic [15:0] count_q;

  // Saturating count of RUN cycles; Start clears it for the new program.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else if (Start) begin
      count_q <= '0;
    end else if ((state_q == ST_RUN) && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign CycleCount = count_q;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational instruction memory model.
module tb_inst_fetch;

  localparam int PW = 11;
  localparam int IW = 9;

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic [PW-1:0] StartAddr;
  logic          Stall;
  logic          BranchAbs;
  logic          BranchRel;
  logic [PW-1:0] Target;
  logic [IW-1:0] InstIn;
  logic [PW-1:0] InstAddress;
  logic          InstValid;
  logic          Halt;
  logic          Done;
  logic [15:0]   CycleCount;
  logic [1:0]    dbg_state;

  logic [IW-1:0] mem [2048];

  int n_checks;
  int n_fails;

  inst_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Stall       (Stall),
    .BranchAbs   (BranchAbs),
    .BranchRel   (BranchRel),
    .Target      (Target),
    .InstIn      (InstIn),
    .InstAddress (InstAddress),
    .InstValid   (InstValid),
    .Halt        (Halt),
    .Done        (Done),
    .CycleCount  (CycleCount),
    .dbg_state   (dbg_state)
  );

  assign InstIn = mem[InstAddress];

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // check task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_at(input logic [PW-1:0] addr);
    Start     = 1'b1;
    StartAddr = addr;
    tick();
    Start     = 1'b0;
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef INST_FETCH_CYCLE_COUNT_EN
    return n[15:0];
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    Reset     = 1'b1;
    Start     = 1'b0;
    StartAddr = '0;
    Stall     = 1'b0;
    BranchAbs = 1'b0;
    BranchRel = 1'b0;
    Target    = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
    for (int i = 0; i < 3; i++) mem[i] = 9'h011 + 9'(i);
    mem[3] = 9'h1FF;
    mem[6] = 9'h1FF;

    // reset state
    #12;
    check("rst_addr",  32'(InstAddress), 32'd0);
    check("rst_valid", 32'(InstValid),   32'd0);
    check("rst_halt",  32'(Halt),        32'd0);
    check("rst_done",  32'(Done),        32'd0);
    check("rst_cnt",   32'(CycleCount),  32'd0);
    Reset = 1'b0;
    tick();
    check("idle_addr",  32'(InstAddress), 32'd0);
    check("idle_valid", 32'(InstValid),   32'd0);

    // sequential run to halt word at address 3
    start_at(11'd0);
    check("seq_a0",    32'(InstAddress), 32'd0);
    check("seq_valid", 32'(InstValid),   32'd1);
    tick(); check("seq_a1", 32'(InstAddress), 32'd1);
    tick(); check("seq_a2", 32'(InstAddress), 32'd2);
    tick(); check("seq_a3", 32'(InstAddress), 32'd3);
    check("seq_done_pre", 32'(Done), 32'd0);
    check("seq_halt_pre", 32'(Halt), 32'd0);
    tick();
    check("halt_level", 32'(Halt),        32'd1);
    check("halt_done",  32'(Done),        32'd1);
    check("halt_addr",  32'(InstAddress), 32'd3);
    check("halt_valid", 32'(InstValid),   32'd0);
    check("halt_cnt",   32'(CycleCount),  32'(exp_cnt(4)));
    tick();
    check("halt_done_off", 32'(Done),        32'd0);
    check("halt_hold",     32'(Halt),        32'd1);
    check("halt_addr2",    32'(InstAddress), 32'd3);

    // restart from HALTED
    start_at(11'd100);
    check("rs_halt",  32'(Halt),        32'd0);
    check("rs_addr",  32'(InstAddress), 32'd100);
    check("rs_valid", 32'(InstValid),   32'd1);
    check("rs_cnt",   32'(CycleCount),  32'd0);

    // branches from PC=10
    start_at(11'd10);
    BranchAbs = 1'b1; Target = 11'd40;
    tick(); check("br_abs", 32'(InstAddress), 32'd40);
    BranchAbs = 1'b0;
    start_at(11'd10);
    BranchRel = 1'b1; Target = 11'h7FD;
    tick(); check("br_rel_neg", 32'(InstAddress), 32'd7);
    BranchRel = 1'b0;
    start_at(11'd10);
    BranchAbs = 1'b1; BranchRel = 1'b1; Target = 11'd40;
    tick(); check("br_both", 32'(InstAddress), 32'd40);
    BranchAbs = 1'b0; BranchRel = 1'b0;

    // wrap cases
    start_at(11'd2047);
    check("wrap_a2047", 32'(InstAddress), 32'd2047);
    tick(); check("wrap_a0", 32'(InstAddress), 32'd0);
    start_at(11'd2046);
    BranchRel = 1'b1; Target = 11'd5;
    tick(); check("rel_wrap", 32'(InstAddress), 32'd3);
    BranchRel = 1'b0;

    // stalled halt word at address 6, branch inputs ignored on the halt cycle
    start_at(11'd6);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", 32'(InstAddress), 32'd6);
      check("stall_halt", 32'(Halt),        32'd0);
      check("stall_done", 32'(Done),        32'd0);
      tick();
    end
    Stall = 1'b0;
    BranchAbs = 1'b1; Target = 11'd40;
    check("stall_addr_last", 32'(InstAddress), 32'd6);
    tick();
    BranchAbs = 1'b0;
    check("stall_halt_taken", 32'(Halt),        32'd1);
    check("stall_done_pulse", 32'(Done),        32'd1);
    check("stall_halt_addr",  32'(InstAddress), 32'd6);
    check("stall_cnt",        32'(CycleCount),  32'(exp_cnt(4)));
    tick();
    check("stall_done_off", 32'(Done), 32'd0);

    // Start coincident with a halt word: Start wins, no Done
    start_at(11'd6);
    check("sh_addr6", 32'(InstAddress), 32'd6);
    start_at(11'd100);
    check("sh_addr",  32'(InstAddress), 32'd100);
    check("sh_halt",  32'(Halt),        32'd0);
    check("sh_done",  32'(Done),        32'd0);
    check("sh_valid", 32'(InstValid),   32'd1);

    // asynchronous reset mid-RUN at PC=5
    start_at(11'd5);
    check("mr_addr5", 32'(InstAddress), 32'd5);
    #2;
    Reset = 1'b1;
    #1;
    check("mr_addr",  32'(InstAddress), 32'd0);
    check("mr_valid", 32'(InstValid),   32'd0);
    check("mr_halt",  32'(Halt),        32'd0);
    check("mr_done",  32'(Done),        32'd0);
    check("mr_cnt",   32'(CycleCount),  32'd0);
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check("mr_idle_addr",  32'(InstAddress), 32'd0);
    check("mr_idle_valid", 32'(InstValid),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
